// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package serial_sub_pkg;

  localparam int SUB_N_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fsub_cell.sv
// One-bit full subtractor: d = x - y - bi, bo set when the bit underflows.
module fsub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~x & bi) | (y & bi);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per clock, LSB first,
// using a single full-subtractor cell and a borrow flop.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int N = SUB_N_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic [N-1:0] diff,
  output logic         bout,
  output logic         busy,
  output logic         done
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  state_t        state, state_nx;
  logic [N-1:0]  areg, breg, dreg;
  logic          br, bout_r;
  logic [CW-1:0] cnt;
  logic          cell_d, cell_bo;
  logic          last;

  assign last = (cnt == CW'(N - 1));

  fsub_cell u_cell (
    .x  (areg[0]),
    .y  (breg[0]),
    .bi (br),
    .d  (cell_d),
    .bo (cell_bo)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last)  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // State register and serial datapath share one sequential process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      areg   <= '0;
      breg   <= '0;
      dreg   <= '0;
      br     <= 1'b0;
      bout_r <= 1'b0;
      cnt    <= '0;
    end else begin
      state <= state_nx;
      unique case (state)
        IDLE: begin
          if (start) begin
            areg   <= a;
            breg   <= b;
            br     <= bin;
            bout_r <= 1'b0;
            cnt    <= '0;
          end
        end
        RUN: begin
          dreg <= {cell_d, dreg[N-1:1]};
          areg <= {1'b0, areg[N-1:1]};
          breg <= {1'b0, breg[N-1:1]};
          br   <= cell_bo;
          // Hold the counter on the final bit so it never wraps.
          if (last) bout_r <= cell_bo;
          else      cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign diff = dreg;
  assign bout = bout_r;

endmodule
